// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction fetch controller. It walks a 6-bit word address
//            through an instruction ROM that answers in the same cycle. Each
//            fetched word is buffered, together with its address, in a small
//            prefetch FIFO. The consumer drains that FIFO through a
//            valid/ready handshake. A redirect flushes the FIFO and restarts
//            fetching at a new address.
//
// Optional : IMEM_FETCH_HALT_ON_ZERO_EN
//            When this macro is defined, an all-zero fetched word marks the
//            end of the program. That word is not queued, fetching freezes,
//            and done rises once the FIFO has drained. Only a redirect or a
//            reset leaves the END state. When the macro is undefined, zero
//            words are ordinary instructions and done is tied low.
//
// Parameters:
//   N             instruction width in bits
//   DEPTH         prefetch FIFO entries (2 or 4)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   imem_addr     word address to the ROM (always equals fetch_pc)
//   imem_q        ROM data for imem_addr, same cycle
//   redirect      branch/jump request; flushes and reloads fetch_pc
//   redirect_addr target word address for redirect
//   instr_valid   FIFO head holds an instruction
//   instr_ready   consumer accepts the head this cycle
//   instr         instruction at FIFO head (zero when empty)
//   instr_pc      word address of instr (zero when empty)
//   done          program end reached and FIFO drained
//
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic [5:0]   imem_addr,
    input  logic [N-1:0] imem_q,
    input  logic         redirect,
    input  logic [5:0]   redirect_addr,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [N-1:0] instr,
    output logic [5:0]   instr_pc,
    output logic         done
);

    // Legal depths are 2 and 4. Both are powers of two, so the read and
    // write pointers wrap on their own without any compare logic.
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_STALL = 2'd1,
        ST_END   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [5:0]    fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [N-1:0]  mem_instr [DEPTH];
    logic [5:0]    mem_pc    [DEPTH];

    logic          pop;
    logic          room;
    logic          fetch_en;
    logic          halt_hit;
    logic          push;

    // ------------------------------------------------------------------------
    // Handshake and fetch qualification
    // ------------------------------------------------------------------------
    always_comb begin
        pop      = (count != '0) && instr_ready;
        // A full FIFO can still take a word when the head leaves this cycle.
        room     = (count < DEPTH_C) || pop;
        fetch_en = (state != ST_END) && room;
`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
        // A zero word is only treated as the end marker when it would
        // actually have been accepted. A word that is still waiting behind
        // a full FIFO has not been fetched yet.
        halt_hit = fetch_en && (imem_q == '0);
`else
        halt_hit = 1'b0;
`endif
        // Redirect wins over everything: the word read this cycle belongs
        // to the abandoned path.
        push     = fetch_en && !halt_hit && !redirect;
    end

    // ------------------------------------------------------------------------
    // Occupancy and state: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        count_nxt = count;
        state_nxt = state;

        if (redirect) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end

        if (redirect) begin
            state_nxt = ST_FETCH;
        end else if (state == ST_END || halt_hit) begin
            state_nxt = ST_END;
        end else if (count_nxt == DEPTH_C) begin
            // The FIFO is full going into the next cycle. Fetch holds unless
            // the consumer pops.
            state_nxt = ST_STALL;
        end else begin
            state_nxt = ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Fetch pointer and FIFO control
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= 6'd0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            count <= count_nxt;
            if (redirect) begin
                // Any handshake this cycle has already completed on the
                // consumer side. Everything left in the FIFO is discarded.
                fetch_pc <= redirect_addr;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    // The 6-bit add wraps 63 -> 0 naturally.
                    fetch_pc <= fetch_pc + 6'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // FIFO storage needs no reset. Its contents are never visible unless
    // count says the entry is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_q;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? mem_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : 6'd0;

`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
    assign done = (state == ST_END) && (count == '0);
`else
    assign done = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Self-checking bench for imem_fetch_ctrl. A queue-based reference
//            model predicts the FIFO contents, the fetch address and done.
//            Directed scenarios are followed by a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam int N     = 32;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [5:0]   imem_addr;
    logic [N-1:0] imem_q;
    logic         redirect = 1'b0;
    logic [5:0]   redirect_addr = 6'd0;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic [N-1:0] instr;
    logic [5:0]   instr_pc;
    logic         done;

    logic [N-1:0] rom [64];

    always #5 clk = ~clk;

    assign imem_q = rom[imem_addr];

    imem_fetch_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_q        (imem_q),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .done          (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the queue holds what the consumer will see
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [N-1:0] w;
        logic [5:0]   pc;
    } ent_t;

    ent_t         mq[$];
    logic [5:0]   m_pc  = 6'd0;
    bit           m_end = 1'b0;
    int           m_sz;
    bit           m_pop;
    bit           m_room;
    logic [N-1:0] m_word;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_pc  = 6'd0;
            m_end = 1'b0;
        end else begin
            m_sz   = mq.size();
            m_pop  = (m_sz > 0) && instr_ready;
            m_room = (m_sz < DEPTH) || m_pop;
            if (m_pop) void'(mq.pop_front());
            if (redirect) begin
                mq.delete();
                m_pc  = redirect_addr;
                m_end = 1'b0;
            end else if (!m_end && m_room) begin
                m_word = rom[m_pc];
`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
                if (m_word == '0) m_end = 1'b1;
                else
`endif
                begin
                    mq.push_back({m_word, m_pc});
                    m_pc = m_pc + 6'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Compare process: every falling edge once enabled
    // ------------------------------------------------------------------------
    bit   cmp_en = 1'b0;
    ent_t c_head;
    bit   c_valid;
    bit   c_done;

    always @(negedge clk) begin
        if (cmp_en) begin
            c_valid = (mq.size() > 0);
            c_head  = c_valid ? mq[0] : '0;
`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
            c_done  = m_end && (mq.size() == 0);
`else
            c_done  = 1'b0;
`endif
            check("model_valid", 64'(instr_valid), 64'(c_valid));
            check("model_instr", 64'(instr),       64'(c_head.w));
            check("model_pc",    64'(instr_pc),    64'(c_head.pc));
            check("model_addr",  64'(imem_addr),   64'(m_pc));
            check("model_done",  64'(done),        64'(c_done));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the falling edge
    // ------------------------------------------------------------------------
    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
    endtask

    task automatic load_seq_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | 32'(i);
    endtask

    initial begin
        load_seq_rom();
        cyc();
        cmp_en = 1'b1;

        // Reset state
        cyc();
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr),       64'd0);
        check("rst_pc",    64'(instr_pc),    64'd0);
        check("rst_addr",  64'(imem_addr),   64'd0);
        check("rst_done",  64'(done),        64'd0);

        // Straight-line stream with consumer always ready
        instr_ready = 1'b1;
        do_reset();
        cyc();
        check("seq_A",   64'(instr),    64'hA000_0000);
        check("seq_pc0", 64'(instr_pc), 64'd0);
        cyc();
        check("seq_B",   64'(instr),    64'hA000_0001);
        check("seq_pc1", 64'(instr_pc), 64'd1);
        cyc();
        check("seq_C",   64'(instr),    64'hA000_0002);
        check("seq_pc2", 64'(instr_pc), 64'd2);

        // Back-pressure: the FIFO saturates, then drains in order
        instr_ready = 1'b0;
        do_reset();
        repeat (5) cyc();
        check("bp_addr",  64'(imem_addr),   64'd2);
        check("bp_valid", 64'(instr_valid), 64'd1);
        check("bp_A",     64'(instr),       64'hA000_0000);
        check("bp_pc0",   64'(instr_pc),    64'd0);
        instr_ready = 1'b1;
        cyc();
        check("bp_B", 64'(instr), 64'hA000_0001);
        cyc();
        check("bp_C", 64'(instr), 64'hA000_0002);

        // Redirect while the FIFO holds pc 3 and 4
        instr_ready = 1'b1;
        do_reset();
        repeat (4) cyc();
        instr_ready = 1'b0;
        cyc();
        check("rd_head3", 64'(instr_pc),  64'd3);
        check("rd_addr5", 64'(imem_addr), 64'd5);
        redirect      = 1'b1;
        redirect_addr = 6'd40;
        cyc();
        redirect = 1'b0;
        check("rd_flush", 64'(instr_valid), 64'd0);
        check("rd_addr",  64'(imem_addr),   64'd40);
        cyc();
        check("rd_valid", 64'(instr_valid), 64'd1);
        check("rd_pc40",  64'(instr_pc),    64'd40);

        // Redirect near the top of the address space: fetch wraps to 0
        instr_ready   = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 6'd62;
        cyc();
        redirect = 1'b0;
        check("wr_flush", 64'(instr_valid), 64'd0);
        cyc();
        check("wr_pc62", 64'(instr_pc), 64'd62);
        check("wr_w62",  64'(instr),    64'hA000_003E);
        cyc();
        check("wr_pc63", 64'(instr_pc), 64'd63);
        cyc();
        check("wr_pc0",  64'(instr_pc), 64'd0);
        cyc();
        check("wr_pc1",  64'(instr_pc), 64'd1);

        // Zero word at pc 2
        rom[2] = '0;
        instr_ready = 1'b1;
        do_reset();
        cyc();
        check("z_A", 64'(instr), 64'hA000_0000);
        cyc();
        check("z_B", 64'(instr), 64'hA000_0001);
        cyc();
`ifdef IMEM_FETCH_HALT_ON_ZERO_EN
        check("z_valid", 64'(instr_valid), 64'd0);
        check("z_done",  64'(done),        64'd1);
        check("z_addr",  64'(imem_addr),   64'd2);
        cyc();
        check("z_hold",  64'(imem_addr),   64'd2);
        check("z_done2", 64'(done),        64'd1);
`else
        check("z_valid", 64'(instr_valid), 64'd1);
        check("z_word",  64'(instr),       64'd0);
        check("z_pc2",   64'(instr_pc),    64'd2);
        check("z_done",  64'(done),        64'd0);
`endif
        rom[2] = 32'hA000_0002;

        // Asynchronous reset with a full FIFO
        instr_ready = 1'b0;
        do_reset();
        repeat (3) cyc();
        check("ar_full", 64'(instr_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("ar_valid", 64'(instr_valid), 64'd0);
        check("ar_instr", 64'(instr),       64'd0);
        check("ar_pc",    64'(instr_pc),    64'd0);
        check("ar_addr",  64'(imem_addr),   64'd0);
        cyc();
        reset = 1'b1;
        cyc();
        check("ar_first", 64'(instr_pc),    64'd0);
        check("ar_fv",    64'(instr_valid), 64'd1);

        // Randomized run over a ROM that contains some zero words
        for (int i = 0; i < 64; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom());
        for (int k = 0; k < 3000; k++) begin
            instr_ready   = ($urandom_range(0, 3) != 0);
            redirect      = ($urandom_range(0, 24) == 0);
            redirect_addr = 6'($urandom_range(0, 63));
            reset         = ($urandom_range(0, 199) != 0);
            cyc();
        end
        reset    = 1'b1;
        redirect = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
